// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART CRC transmitter between four requesters. A requester
//   raises req[i] with its byte on req_data[8i+7:8i]; the arbiter picks one
//   requester round-robin, latches its byte, and strobes the transmitter.
//   Once the frame ends, the owner receives one ack pulse (tx_done seen) or
//   one err pulse (WAIT_DONE timed out).
//
//   Handshake: req[i] is a level request and stays high until ack[i] or err[i]
//   pulses. grant is the one-hot owner from ISSUE through RELEASE. tx_start
//   is the valid strobe to the transmitter and tx_busy is its not-ready. A
//   start is taken in exactly the cycle where tx_start=1, which is ISSUE with
//   tx_busy=0. tx_done is a one-cycle completion pulse that counts only in
//   WAIT_DONE.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req[3:0]         per-requester send request
//   req_data[31:0]   byte i on bits [8i+7:8i]
//   grant[3:0]       one-hot current owner of the transmitter
//   ack[3:0]         one-cycle pulse: frame completed
//   err[3:0]         one-cycle pulse: frame abandoned on timeout
//   tx_start         one-cycle start strobe to the transmitter
//   tx_data[7:0]     latched byte, stable ISSUE..RELEASE
//   tx_busy          transmitter occupied
//   tx_done          transmitter finished the stop bit
//   timeout_count    saturating count of timeout aborts
//   state_dbg[1:0]   current FSM state (0 IDLE, 1 ISSUE, 2 WAIT_DONE, 3 RELEASE)
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [7:0]             timeout_count,
  output logic [1:0]             state_dbg
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [15:0]      timer;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;

  // Round-robin search. It walks offsets from farthest to nearest, so the
  // nearest active requester after last_ptr is the final one assigned.
  // Offset NUM_REQ wraps back to last_ptr, which lets a lone requester win
  // on every frame.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_ptr + PTR_W'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // The start strobe is combinational so the transmitter sees it in the same
  // cycle that tx_busy drops.
  assign tx_start  = (state == S_ISSUE) && !tx_busy;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      grant_idx     <= '0;
      ack           <= '0;
      err           <= '0;
      tx_data       <= '0;
      timer         <= '0;
      timeout_count <= '0;
      last_ptr      <= PTR_W'(NUM_REQ - 1);
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant     <= ONE_HOT0 << pick_idx;
            grant_idx <= pick_idx;
            tx_data   <= req_data[{pick_idx, 3'b000} +: 8];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Waits for the transmitter without limit. The timeout covers only
          // a frame that has already started.
          if (!tx_busy) begin
            timer <= '0;
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          timer <= timer + 16'd1;
          if (tx_done) begin
            // Completion takes priority when it lands on the terminal cycle.
            ack   <= grant;
            state <= S_RELEASE;
          end else if (timer == TIMER_LAST) begin
            err   <= grant;
            state <= S_RELEASE;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
          end
        end
        S_RELEASE: begin
          last_ptr <= grant_idx;
          grant    <= '0;
          state    <= S_IDLE;
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. It uses a short timeout of 16 cycles. The
// reference model is a round-robin pointer, a saturating timeout counter and
// a queue of expected bytes, all derived from the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant, ack, err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done;
  logic [7:0]  timeout_count;
  logic [1:0]  state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_last = 3;
  int model_to   = 0;
  logic [3:0] obs_grant;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .timeout_count(timeout_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next owner: first active requester after 'last', wrapping.
  function automatic int rr_pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One whole frame, starting and ending in IDLE. done_k is the WAIT_DONE
  // cycle index that gets the tx_done pulse. A negative value or one past
  // T-1 means no completion, so the frame times out.
  task automatic do_frame(input logic [3:0] r, input logic [31:0] d,
                          input int busy_n, input int done_k, input bit drop_req);
    int idx;
    int n_wait;
    bit ok_done;
    logic [3:0] g;
    logic [7:0] b;
    logic [7:0] qb;
    idx     = rr_pick(model_last, r);
    g       = 4'(1 << idx);
    b       = d[8*idx +: 8];
    exp_q.push_back(b);
    ok_done = (done_k >= 0) && (done_k <= T - 1);
    n_wait  = ok_done ? done_k + 1 : T;

    req = r; req_data = d; tx_busy = (busy_n > 0); tx_done = 1'b0;
    tick();
    obs_grant = grant;
    total_cnt++;
    if (grant !== g) $display("FAIL grant: got %b expected %b", grant, g);
    else pass_cnt++;
    // Later changes to the request inputs must not disturb the frame.
    req_data = $urandom;
    if (drop_req) req = 4'b0;

    for (int i = 0; i < busy_n; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      #1;
      total_cnt++;
      if (tx_start !== 1'b0 || err !== 4'b0)
        $display("FAIL busy_hold: got start=%b err=%b expected start=0 err=0", tx_start, err);
      else pass_cnt++;
      tick();
    end
    tx_done = 1'b0; tx_busy = 1'b0;
    #1;
    qb = exp_q.pop_front();
    total_cnt++;
    if (tx_start !== 1'b1 || tx_data !== qb)
      $display("FAIL issue: got start=%b data=%h expected start=1 data=%h", tx_start, tx_data, qb);
    else pass_cnt++;
    tick();

    for (int k = 0; k < n_wait; k++) begin
      if (ok_done && k == done_k) tx_done = 1'b1;
      total_cnt++;
      if ({tx_start, ack, err, grant} !== {1'b0, 4'b0, 4'b0, g})
        $display("FAIL wait_quiet: got start=%b ack=%b err=%b grant=%b expected 0/0000/0000/%b",
                 tx_start, ack, err, grant, g);
      else pass_cnt++;
      tick();
      tx_done = 1'b0;
    end

    // RELEASE
    if (!ok_done) model_to = (model_to < 255) ? model_to + 1 : 255;
    total_cnt++;
    if (ack !== (ok_done ? g : 4'b0) || err !== (ok_done ? 4'b0 : g))
      $display("FAIL release: got ack=%b err=%b expected ack=%b err=%b",
               ack, err, ok_done ? g : 4'b0, ok_done ? 4'b0 : g);
    else pass_cnt++;
    total_cnt++;
    if (timeout_count !== 8'(model_to) || tx_data !== b)
      $display("FAIL release_state: got count=%0d data=%h expected count=%0d data=%h",
               timeout_count, tx_data, model_to, b);
    else pass_cnt++;
    req = 4'b0;
    tick();

    // IDLE
    total_cnt++;
    if ({grant, ack, err, tx_start} !== 13'b0)
      $display("FAIL idle_after: got grant=%b ack=%b err=%b start=%b expected all 0",
               grant, ack, err, tx_start);
    else pass_cnt++;
    model_last = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; req_data = 32'h0; tx_busy = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({grant, ack, err, tx_start, tx_data, timeout_count} !== 29'b0)
      $display("FAIL reset: got grant=%b ack=%b err=%b start=%b data=%h count=%0d expected all 0",
               grant, ack, err, tx_start, tx_data, timeout_count);
    else pass_cnt++;
    rst = 1'b0;
    model_last = 3; model_to = 0;
  endtask

  task automatic test_idle();
    req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      tick();
      total_cnt++;
      if ({grant, ack, err, tx_start} !== 13'b0)
        $display("FAIL idle: got grant=%b ack=%b err=%b start=%b expected all 0",
                 grant, ack, err, tx_start);
      else pass_cnt++;
    end
    tx_done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, $urandom, 0, $urandom_range(0, 12), 1'b0);
      total_cnt++;
      if (obs_grant !== exp_seq[i])
        $display("FAIL rr_seq: frame %0d got %b expected %b", i, obs_grant, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    d = $urandom;
    d[7:0] = 8'hA5;
    do_frame(4'b0001, d, 0, 9, 1'b0);
  endtask

  task automatic test_busy();
    do_frame(4'b0100, $urandom, 5, 3, 1'b0);
  endtask

  task automatic test_drop_req();
    do_frame(4'b1000, $urandom, 2, 4, 1'b1);
  endtask

  task automatic test_timeout();
    do_frame(4'b0010, $urandom, 0, -1, 1'b0);
    total_cnt++;
    if (timeout_count !== 8'd1)
      $display("FAIL timeout_count1: got %0d expected 1", timeout_count);
    else pass_cnt++;
  endtask

  task automatic test_coincident();
    do_frame(4'b0001, $urandom, 0, T - 1, 1'b0);
    total_cnt++;
    if (timeout_count !== 8'd1)
      $display("FAIL coincident_count: got %0d expected 1", timeout_count);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_frame(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3),
               $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      do_frame(4'($urandom_range(1, 15)), $urandom, 0, -1, 1'b0);
    end
    total_cnt++;
    if (timeout_count !== 8'd255)
      $display("FAIL saturation: got %0d expected 255", timeout_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    req = 4'b0100; req_data = $urandom; tx_busy = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1; req = 4'b0;
    tick();
    total_cnt++;
    if ({grant, ack, err, tx_start, tx_data, timeout_count} !== 29'b0)
      $display("FAIL reset_mid: got grant=%b ack=%b err=%b start=%b data=%h count=%0d expected all 0",
               grant, ack, err, tx_start, tx_data, timeout_count);
    else pass_cnt++;
    rst = 1'b0;
    model_last = 3; model_to = 0;
    exp_q.delete();
    tick();
    total_cnt++;
    if ({ack, err} !== 8'b0)
      $display("FAIL reset_no_pulse: got ack=%b err=%b expected 0", ack, err);
    else pass_cnt++;
    do_frame(4'b1111, $urandom, 0, 2, 1'b0);
    total_cnt++;
    if (obs_grant !== 4'b0001)
      $display("FAIL reset_first_grant: got %b expected 0001", obs_grant);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_round_robin();
    test_single();
    test_busy();
    test_drop_req();
    test_timeout();
    test_coincident();
    test_random();
    test_saturation();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: TIMEOUT_CYCLES, 16000, maximum cycles in WAIT_DONE before the frame is abandoned (one data+CRC+stop frame is about 14600 cycles at clks_per_bit=1042).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  4  per-requester send request; held high until that requester's ack or err.
REQ-006 req_data  input  32  byte for requester i on bits [8i+7:8i].
REQ-007 grant  output  4  one-hot; identifies the requester that currently owns the transmitter.
REQ-008 ack  output  4  one-cycle pulse to the owning requester on successful frame completion.
REQ-009 err  output  4  one-cycle pulse to the owning requester on timeout abort.
REQ-010 tx_start  output  1  one-cycle start strobe to the UART CRC transmitter.
REQ-011 tx_data  output  8  byte to transmit; stable from ISSUE through RELEASE.
REQ-012 tx_busy  input  1  transmitter is occupied.
REQ-013 tx_done  input  1  one-cycle pulse: the transmitter finished the stop bit.
REQ-014 timeout_count  output  8  number of timeout aborts, saturating at 255.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_DONE and RELEASE; any illegal encoding SHALL go to IDLE on the next cycle.
REQ-016 IDLE, with req != 0: select the requester by round-robin, searching ascending from (last_ptr+1) mod 4 with wrap. Latch its byte into tx_data, set grant one-hot, then go to ISSUE.
REQ-017 IDLE, with req == 0: remain in IDLE; grant=0, tx_start=0.
REQ-018 ISSUE: tx_start SHALL equal (state==ISSUE && !tx_busy), decoded combinationally. ISSUE SHALL go to WAIT_DONE in the same cycle tx_start is high. It SHALL hold indefinitely while tx_busy=1, with no timeout.
REQ-019 Latency: req rises in IDLE at cycle t -> grant valid at t+1 -> tx_start at t+1 if tx_busy=0.
REQ-020 WAIT_DONE: a 16-bit timer clears on entry and increments each cycle.
REQ-021 WAIT_DONE with tx_done=1: assert ack for the granted index in the next cycle (RELEASE), then go to RELEASE.
REQ-022 WAIT_DONE with timer == TIMEOUT_CYCLES-1 and tx_done=0: assert err for the granted index in RELEASE, increment timeout_count (saturate at 255), then go to RELEASE.
REQ-023 tx_done and the timeout terminal cycle together: tx_done SHALL win; ack only, no err, no count.
REQ-024 tx_done outside WAIT_DONE SHALL be ignored.
REQ-025 RELEASE lasts one cycle: ack or err pulses, last_ptr <= granted index, grant <= 0 at exit, then go to IDLE. The minimum gap between frames is therefore 1 cycle in IDLE.
REQ-026 Deasserting req after grant SHALL NOT cancel the frame; req_data changes after the latch SHALL NOT affect tx_data.
REQ-027 At most one bit of grant, ack and err SHALL be set at any time; ack and err SHALL never be set together.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, grant=0, ack=0, err=0, tx_data=0, timer=0, timeout_count=0, last_ptr=3 (requester 0 wins first).
REQ-029 rst in any state SHALL abort the frame with no ack or err; outputs are at reset values on the cycle after the edge.

Verification
REQ-030 req=0001, req_data[7:0]=0xA5, tx_busy=0, tx_done 10 cycles after tx_start -> grant=0001 at t+1; tx_start high one cycle with tx_data=0xA5; ack=0001 one cycle; grant=0 afterwards.
REQ-031 req=1111 held, each frame completing normally -> grant sequence 0001, 0010, 0100, 1000, 0001; exactly one ack per frame.
REQ-032 req=0100 with tx_busy=1 for 5 cycles in ISSUE -> tx_start stays 0 for those 5 cycles, then pulses on the first cycle tx_busy=0; no err.
REQ-033 TIMEOUT_CYCLES=16, no tx_done -> err pulse in the cycle after the 16th WAIT_DONE cycle; timeout_count=1; after 300 timeouts timeout_count=255.
REQ-034 tx_done coincident with the terminal timeout cycle -> ack pulse, err=0, timeout_count unchanged.
REQ-035 rst asserted during WAIT_DONE for requester 2, then req=1111 -> all outputs 0 after rst; next grant=0001.
